// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store responder serialising 8/16/32-bit accesses onto a byte-wide req/ack bus
// Optional per-byte bus timeout: define MEM_LSU_TIMEOUT_EN.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_wr_en_i,
    input  logic        mem_rd_en_i,
    input  logic [1:0]  mem_acc_w_i,
    input  logic [1:0]  mem_acc_r_i,
    input  logic        mem_r_sext_i,
    output logic        mem_wr_ready_o,
    output logic        mem_rd_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [7:0]  bus_wdata_o,
    input  logic [7:0]  bus_rdata_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rbuf_q, rdata_q;
    logic [1:0]  last_q, k_q;
    logic        sext_q, rd_q, err_q;

    logic        req_any;
    logic [1:0]  req_size;
    logic        req_bad;
    logic [1:0]  req_last;
    logic        last_ack;
    logic        timeout_hit;
    logic [31:0] rbuf_m;

    // Store wins when both enables are set, so size follows the chosen direction.
    assign req_any  = mem_wr_en_i | mem_rd_en_i;
    assign req_size = mem_wr_en_i ? mem_acc_w_i : mem_acc_r_i;

    always_comb begin
        req_bad  = 1'b0;
        req_last = 2'd0;
        case (req_size)
            2'd0: begin req_bad = 1'b0;                      req_last = 2'd0; end
            2'd1: begin req_bad = mem_addr_i[0];             req_last = 2'd1; end
            2'd2: begin req_bad = (mem_addr_i[1:0] != 2'd0); req_last = 2'd3; end
            default: begin req_bad = 1'b1;                   req_last = 2'd0; end
        endcase
    end

    assign last_ack = (state_q == S_XFER) && bus_ack_i && (k_q == last_q);

`ifdef MEM_LSU_TIMEOUT_EN
    logic [31:0] tcnt_q;

    assign timeout_hit = (state_q == S_XFER) && !bus_ack_i && (tcnt_q == TIMEOUT - 1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tcnt_q <= '0;
        end else if (state_q != S_XFER || bus_ack_i) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + 32'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Read buffer with the byte arriving this cycle merged in, used on the final ack.
    always_comb begin
        rbuf_m = rbuf_q;
        rbuf_m[{k_q, 3'b000} +: 8] = bus_rdata_i;
    end

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] last,
                                           input logic sx);
        case (last)
            2'd0:    extend = {{24{sx & v[7]}}, v[7:0]};
            2'd1:    extend = {{16{sx & v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_any) state_d = req_bad ? S_DONE : S_XFER;
            S_XFER: if (last_ack || timeout_hit) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            last_q  <= '0;
            k_q     <= '0;
            sext_q  <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        addr_q  <= mem_addr_i;
                        wdata_q <= mem_wdata_i;
                        rd_q    <= ~mem_wr_en_i;
                        sext_q  <= mem_r_sext_i;
                        last_q  <= req_last;
                        err_q   <= req_bad;
                        k_q     <= 2'd0;
                        rbuf_q  <= '0;
                    end
                end
                S_XFER: begin
                    if (bus_ack_i) begin
                        k_q <= k_q + 2'd1;
                        if (rd_q) rbuf_q <= rbuf_m;
                        if (rd_q && k_q == last_q) rdata_q <= extend(rbuf_m, last_q, sext_q);
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_wr_ready_o = 1'b0;
        mem_rd_ready_o = 1'b0;
        mem_err_o      = 1'b0;
        bus_req_o      = 1'b0;
        bus_we_o       = 1'b0;
        bus_addr_o     = '0;
        bus_wdata_o    = '0;
        case (state_q)
            S_XFER: begin
                bus_req_o   = 1'b1;
                bus_we_o    = ~rd_q;
                bus_addr_o  = addr_q + {30'd0, k_q};
                bus_wdata_o = wdata_q[{k_q, 3'b000} +: 8];
            end
            S_DONE: begin
                mem_wr_ready_o = ~rd_q;
                mem_rd_ready_o = rd_q;
                mem_err_o      = err_q;
            end
            default: ;
        endcase
    end

    assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

`ifdef MEM_LSU_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 16;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic        mem_wr_en = 1'b0, mem_rd_en = 1'b0;
    logic [1:0]  mem_acc_w = '0, mem_acc_r = '0;
    logic        mem_r_sext = 1'b0;
    logic        mem_wr_ready_o, mem_rd_ready_o, mem_err_o;
    logic [31:0] mem_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [7:0]  bus_wdata_o;
    logic [7:0]  bus_rdata = '0;
    logic        bus_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    int          wcnt, req_cyc, rdy_cyc;
    logic        rdy_err, rdy_rd;
    logic [31:0] w_addr [8];
    logic [7:0]  w_data [8];
    int          w_cyc  [8];
    logic [31:0] r_addr [64];

    mem_lsu #(.TIMEOUT(TMO)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_wr_en_i(mem_wr_en), .mem_rd_en_i(mem_rd_en),
        .mem_acc_w_i(mem_acc_w), .mem_acc_r_i(mem_acc_r), .mem_r_sext_i(mem_r_sext),
        .mem_wr_ready_o(mem_wr_ready_o), .mem_rd_ready_o(mem_rd_ready_o),
        .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic access(input logic wr, input logic rd, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d, input logic sx,
                          input int waits, input logic [31:0] src);
        int wl;
        logic [31:0] sh;
        wl = waits; wcnt = 0; req_cyc = 0; rdy_cyc = -1; rdy_err = 1'b0; rdy_rd = 1'b0;
        mem_addr = a; mem_wdata = d; mem_wr_en = wr; mem_rd_en = rd;
        mem_acc_w = sz; mem_acc_r = sz; mem_r_sext = sx;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); @(negedge clk);
            bus_ack = 1'b0;
            if (mem_wr_ready_o || mem_rd_ready_o) begin
                rdy_cyc = c; rdy_err = mem_err_o; rdy_rd = mem_rd_ready_o;
                break;
            end
            if (bus_req_o) begin
                r_addr[req_cyc] = bus_addr_o;
                req_cyc++;
                if (wl > 0) begin
                    wl--;
                end else begin
                    bus_ack = 1'b1;
                    sh = src >> {bus_addr_o[1:0], 3'b000};
                    bus_rdata = sh[7:0];
                    if (bus_we_o && wcnt < 8) begin
                        w_addr[wcnt] = bus_addr_o; w_data[wcnt] = bus_wdata_o; w_cyc[wcnt] = c;
                        wcnt++;
                    end
                end
            end
        end
        mem_wr_en = 1'b0; mem_rd_en = 1'b0; bus_ack = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    logic [31:0] exp_a [4] = '{32'h100, 32'h101, 32'h102, 32'h103};
    logic [7:0]  exp_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    initial begin
        #12;
        check("rst_req", {31'd0, bus_req_o}, 32'd0);
        check("rst_rdata", mem_rdata_o, 32'd0);
        check("rst_ready", {30'd0, mem_wr_ready_o, mem_rd_ready_o}, 32'd0);
        check("rst_err", {31'd0, mem_err_o}, 32'd0);
        @(negedge clk); rstn = 1'b1; @(negedge clk);

        access(1'b1, 1'b0, 2'd2, 32'h100, 32'hDEADBEEF, 1'b0, 0, 32'd0);
        check("wst_rdy", rdy_cyc, 32'd5);
        check("wst_err", {31'd0, rdy_err}, 32'd0);
        check("wst_cnt", wcnt, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wst_addr%0d", i), w_addr[i], exp_a[i]);
            check($sformatf("wst_data%0d", i), {24'd0, w_data[i]}, {24'd0, exp_b[i]});
            check($sformatf("wst_cyc%0d", i), w_cyc[i], i + 1);
        end

        access(1'b0, 1'b1, 2'd0, 32'h203, 32'd0, 1'b1, 0, 32'h80000000);
        check("bld_sx_rdy", rdy_cyc, 32'd2);
        check("bld_sx_rd", {31'd0, rdy_rd}, 32'd1);
        check("bld_sx_data", mem_rdata_o, 32'hFFFFFF80);
        access(1'b0, 1'b1, 2'd0, 32'h203, 32'd0, 1'b0, 0, 32'h80000000);
        check("bld_zx_rdy", rdy_cyc, 32'd2);
        check("bld_zx_data", mem_rdata_o, 32'h00000080);

        access(1'b0, 1'b1, 2'd1, 32'h40, 32'd0, 1'b0, 3, 32'h00001234);
        check("hld_rdy", rdy_cyc, 32'd6);
        check("hld_reqcyc", req_cyc, 32'd5);
        for (int i = 0; i < 3; i++) check($sformatf("hld_hold%0d", i), r_addr[i], 32'h40);
        check("hld_addr1", r_addr[4], 32'h41);
        check("hld_data", mem_rdata_o, 32'h00001234);
        check("hld_err", {31'd0, rdy_err}, 32'd0);

        access(1'b1, 1'b0, 2'd2, 32'h102, 32'h11223344, 1'b0, 0, 32'd0);
        check("mis_rdy", rdy_cyc, 32'd1);
        check("mis_err", {31'd0, rdy_err}, 32'd1);
        check("mis_noreq", req_cyc, 32'd0);

        access(1'b0, 1'b1, 2'd1, 32'h41, 32'd0, 1'b1, 0, 32'hFFFFFFFF);
        check("mish_err", {31'd0, rdy_err}, 32'd1);
        check("mish_keep", mem_rdata_o, 32'h00001234);

        access(1'b0, 1'b1, 2'd3, 32'h0, 32'd0, 1'b0, 0, 32'hFFFFFFFF);
        check("rsv_rdy", rdy_cyc, 32'd1);
        check("rsv_err", {31'd0, rdy_err}, 32'd1);
        check("rsv_keep", mem_rdata_o, 32'h00001234);

`ifdef MEM_LSU_TIMEOUT_EN
        access(1'b0, 1'b1, 2'd2, 32'h300, 32'd0, 1'b0, 1000, 32'hFFFFFFFF);
        check("tmo_reqcyc", req_cyc, 32'd4);
        check("tmo_rdy", rdy_cyc, 32'd5);
        check("tmo_rd", {31'd0, rdy_rd}, 32'd1);
        check("tmo_err", {31'd0, rdy_err}, 32'd1);
        check("tmo_keep", mem_rdata_o, 32'h00001234);
`endif

        // Both enables set: only the store happens.
        access(1'b1, 1'b1, 2'd0, 32'h20, 32'h000000A5, 1'b0, 0, 32'd0);
        check("pri_wr", {30'd0, rdy_rd, rdy_err}, 32'd0);
        check("pri_cnt", wcnt, 32'd1);
        check("pri_data", {24'd0, w_data[0]}, 32'hA5);

        mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF; mem_acc_w = 2'd2;
        mem_wr_en = 1'b1; bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin @(posedge clk); @(negedge clk); end
        check("rst_mid_addr", bus_addr_o, 32'h102);
        #1 rstn = 1'b0;
        #1 check("rst_mid_drop", {31'd0, bus_req_o}, 32'd0);
        mem_wr_en = 1'b0; bus_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            check("rst_mid_nordy", {30'd0, mem_wr_ready_o, mem_rd_ready_o}, 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);
        access(1'b1, 1'b0, 2'd0, 32'h10, 32'h0000005A, 1'b0, 0, 32'd0);
        check("post_rdy", rdy_cyc, 32'd2);
        check("post_cnt", wcnt, 32'd1);
        check("post_addr", w_addr[0], 32'h10);
        check("post_data", {24'd0, w_data[0]}, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store responder on the core's data-memory port. Serves the requests the control path issues: write/read enable, access size, load sign-extension.
- Drives `mem_wr_ready`/`mem_rd_ready` back to stall or advance the PC.
- Turns each 8/16/32-bit access into a sequence of byte transfers on a little-endian byte-wide bus with a req/ack handshake.
- Sits between the core datapath and external data SRAM/peripherals.

Parameters:
- TIMEOUT, 16, bus wait cycles per byte before abort (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- mem_addr_i  in  32  byte address of the access.
- mem_wdata_i  in  32  store data, LSB-aligned.
- mem_wr_en_i  in  1  store request.
- mem_rd_en_i  in  1  load request.
- mem_acc_w_i  in  2  store size: 0=byte, 1=half, 2=word, 3=reserved.
- mem_acc_r_i  in  2  load size, same encoding.
- mem_r_sext_i  in  1  1 = sign-extend load result, 0 = zero-extend.
- mem_wr_ready_o  out  1  one-cycle pulse: store finished.
- mem_rd_ready_o  out  1  one-cycle pulse: load finished, mem_rdata_o valid.
- mem_rdata_o  out  32  load result; held until the next load completes.
- mem_err_o  out  1  one-cycle pulse with the ready pulse: access aborted.
- bus_req_o  out  1  byte transfer request.
- bus_we_o  out  1  1 = write byte.
- bus_addr_o  out  32  byte address.
- bus_wdata_o  out  8  write byte.
- bus_rdata_i  in  8  read byte, valid when bus_ack_i=1.
- bus_ack_i  in  1  transfer accepted/completed this cycle.

Behaviour:
- Reset (async, rstn_i=0): state IDLE.
  - All outputs 0, including mem_rdata_o.
  - bus_req_o drops immediately, even mid-transfer.
  - Byte counter and timeout counter cleared.
- States and transitions:
  - IDLE:
    - Samples request each cycle; mem_wr_en_i has priority over mem_rd_en_i (both set = store only).
    - Captures addr, wdata, size (N = 1/2/4 bytes), sext and direction into internal registers.
    - Size 3, or misalignment (half with addr[0]=1, word with addr[1:0]!=0) -> DONE with error flag, no bus traffic.
    - Otherwise -> XFER, byte index k=0.
  - XFER:
    - bus_req_o=1, bus_addr_o=addr+k, bus_we_o=direction, bus_wdata_o=wdata[8k+7:8k].
    - On a cycle with bus_ack_i=1:
      - Read: rbuf[8k+7:8k] <= bus_rdata_i.
      - k <= k+1.
      - If k==N-1 -> DONE.
    - bus_req_o stays high between bytes; addr/wdata change only after an acked edge.
    - Without ack: outputs held stable.
  - DONE (one cycle):
    - Pulses mem_wr_ready_o or mem_rd_ready_o; mem_err_o=1 if error flag.
    - On a successful load, mem_rdata_o <= rbuf extended from N bytes per sext (byte: bit 7, half: bit 15).
    - -> IDLE.
- Aborted load: mem_rdata_o unchanged.
- Latency: a zero-wait bus (ack in the same cycle as req) gives the ready pulse N+1 cycles after the request is sampled in IDLE. Each wait cycle adds 1.
- Request inputs are ignored outside IDLE. The core keeps them stable while stalled; a new request is accepted in the cycle after DONE.
- Address arithmetic addr+k wraps modulo 2^32; unreachable for aligned accesses.
- bus_ack_i outside XFER is ignored.

Optional Feature:
- Macro: MEM_LSU_TIMEOUT_EN.
- Defined:
  - A per-byte counter counts XFER cycles with bus_ack_i=0 and resets on ack.
  - On reaching TIMEOUT: drop bus_req_o, go to DONE with the error flag (mem_err_o pulses with the ready pulse).
  - Partially read data is discarded.
- Undefined: no counter; XFER waits indefinitely; mem_err_o reports only misalign/reserved-size.

Test Plan:
- Word store 0xDEADBEEF to 0x100, bus acks every cycle -> bytes EF,BE,AD,DE at 0x100..0x103 on consecutive cycles. mem_wr_ready_o pulses 5 cycles after the request; mem_err_o=0.
- Byte load from 0x203 returning 0x80, sext=1 -> mem_rdata_o=0xFFFFFF80 with the ready pulse at cycle 2. Same with sext=0 -> 0x00000080.
- Half load from 0x40 with bus_ack delayed 3 cycles on byte 0; bytes 0x34,0x12 -> bus_req_o/bus_addr_o=0x40 held for 3 cycles. mem_rdata_o=0x00001234; ready at cycle 6.
- Word store to 0x102 -> no bus_req_o; mem_wr_ready_o and mem_err_o pulse together 1 cycle after the request.
- rstn_i asserted during byte 2 of a word store -> bus_req_o low immediately, no ready pulse. After release, a new byte store to 0x10 completes normally.
- With MEM_LSU_TIMEOUT_EN and TIMEOUT=4, bus never acks on a word load -> bus_req_o high exactly 4 cycles. mem_rd_ready_o and mem_err_o pulse; prior mem_rdata_o unchanged.
